// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop sync, per-button debounce, press pulses, direction encode, shoot FSM.
// Define BTN_AUTOFIRE_EN to build the shoot auto-repeat (REPEAT state and repeat counter).
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bt_w,
   input  logic       bt_a,
   input  logic       bt_s,
   input  logic       bt_d,
   input  logic       bt_st,
   output logic [4:0] btn_level,
   output logic [4:0] btn_press,
   output logic       move_valid,
   output logic [1:0] move_dir,
   output logic       shoot_pulse
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("button_conditioner: cycle parameters must be at least 1");
   end

`ifdef BTN_AUTOFIRE_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW   = $clog2(RMAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} shoot_state_e;

   logic [RW-1:0] rc_q, rc_d;
`else
   typedef enum logic {S_IDLE, S_HELD} shoot_state_e;
`endif

   logic [4:0]    raw;
   logic [4:0]    sync1_q, sync2_q;
   logic [4:0]    level_q, level_d;
   logic [4:0]    press_q, press_d;
   logic [CW-1:0] cnt_q [5];
   logic [CW-1:0] cnt_d [5];
   logic [1:0]    dir_q, dir_d;
   logic [1:0]    prio_dir;
   shoot_state_e  state_q, state_d;

   assign raw       = {bt_st, bt_d, bt_s, bt_a, bt_w};
   assign btn_level = level_q;
   assign btn_press = press_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         press_q <= '0;
         dir_q   <= '0;
         state_q <= S_IDLE;
         for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= '0;
`ifdef BTN_AUTOFIRE_EN
         rc_q    <= '0;
`endif
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         dir_q   <= dir_d;
         state_q <= state_d;
         for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
`ifdef BTN_AUTOFIRE_EN
         rc_q    <= rc_d;
`endif
      end
   end

   // Counter only runs while the synced input disagrees with the accepted level.
   always_comb begin
      level_d = level_q;
      for (int unsigned i = 0; i < 5; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) level_d[i] = sync2_q[i];
            else                      cnt_d[i]   = cnt_q[i] + 1'b1;
         end
      end
      press_d = level_d & ~level_q;
   end

   always_comb begin
      move_valid = |level_q[3:0];
      prio_dir   = 2'b11;
      if      (level_q[0]) prio_dir = 2'b00;
      else if (level_q[2]) prio_dir = 2'b01;
      else if (level_q[1]) prio_dir = 2'b10;
      move_dir = move_valid ? prio_dir : dir_q;
      dir_d    = move_dir;
   end

   always_comb begin
      state_d     = state_q;
      shoot_pulse = 1'b0;
`ifdef BTN_AUTOFIRE_EN
      rc_d        = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (press_q[4]) begin
               shoot_pulse = 1'b1;
               state_d     = S_HELD;
            end
         end
         S_HELD: begin
            if (!level_q[4]) state_d = S_IDLE;
`ifdef BTN_AUTOFIRE_EN
            else if (rc_q == RW'(REPEAT_DELAY - 1)) begin
               shoot_pulse = 1'b1;
               state_d     = S_REPEAT;
            end
            else rc_d = rc_q + 1'b1;
`endif
         end
`ifdef BTN_AUTOFIRE_EN
         S_REPEAT: begin
            if (!level_q[4]) state_d = S_IDLE;
            else if (rc_q == RW'(REPEAT_PERIOD - 1)) shoot_pulse = 1'b1;
            else rc_d = rc_q + 1'b1;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: constant-expectation table, corner sequences, random stimulus vs a history-based model.
module tb_button_conditioner;

   localparam int D  = 8;
   localparam int RD = 20;
   localparam int RP = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bt_w, bt_a, bt_s, bt_d, bt_st;
   logic [4:0] btn_level, btn_press;
   logic       move_valid;
   logic [1:0] move_dir;
   logic       shoot_pulse;

   button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bt_w       (bt_w),
      .bt_a       (bt_a),
      .bt_s       (bt_s),
      .bt_d       (bt_d),
      .bt_st      (bt_st),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .move_valid (move_valid),
      .move_dir   (move_dir),
      .shoot_pulse(shoot_pulse)
   );

   always #5 clk = ~clk;

`ifdef BTN_AUTOFIRE_EN
   localparam bit AF = 1'b1;
`else
   localparam bit AF = 1'b0;
`endif

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model: level flips once the last D synced samples all disagree with it
   logic [4:0] m_s1, m_s2, m_level, m_press;
   logic [1:0] m_dir;
   int         m_age;
   bit         m_shoot;
   logic [4:0] s_hist [$];

   typedef struct {
      logic [4:0] raw;
      int         n;
      logic [4:0] lvl;
      logic [4:0] prs;
      logic       vld;
      logic [1:0] dir;
      logic       sht;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(input logic [4:0] raw, input int n, input logic [4:0] lvl,
                               input logic [4:0] prs, input logic vld, input logic [1:0] dir,
                               input logic sht);
      vec_t v;
      v.raw = raw; v.n = n; v.lvl = lvl; v.prs = prs; v.vld = vld; v.dir = dir; v.sht = sht;
      return v;
   endfunction

   function automatic logic [1:0] prio(input logic [4:0] l);
      if (l[0]) return 2'b00;
      if (l[2]) return 2'b01;
      if (l[1]) return 2'b10;
      return 2'b11;
   endfunction

   function automatic logic [13:0] dut_vec();
      return {btn_level, btn_press, move_valid, move_dir, shoot_pulse};
   endfunction

   function automatic logic [13:0] model_vec();
      return {m_level, m_press, |m_level[3:0], m_dir, m_shoot};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_dir = '0;
      m_age = -1; m_shoot = 1'b0;
      s_hist.delete();
   endtask

   task automatic model_edge(input logic [4:0] raw);
      logic [4:0] old;
      bit         all_diff;
      old = m_level;
      s_hist.push_back(m_s2);
      if (s_hist.size() > D) void'(s_hist.pop_front());
      if (s_hist.size() == D) begin
         for (int i = 0; i < 5; i++) begin
            all_diff = 1'b1;
            foreach (s_hist[j]) if (s_hist[j][i] == old[i]) all_diff = 1'b0;
            if (all_diff) m_level[i] = ~old[i];
         end
      end
      m_press = m_level & ~old;
      m_s2 = m_s1;
      m_s1 = raw;
      if (|m_level[3:0]) m_dir = prio(m_level);
      if (m_press[4])                  m_age = 0;
      else if (m_age >= 0 && m_level[4]) m_age = m_age + 1;
      else                             m_age = -1;
      m_shoot = (m_age == 0) || (AF && m_age >= RD && ((m_age - RD) % RP) == 0);
   endtask

   task automatic drive(input logic [4:0] raw);
      {bt_st, bt_d, bt_s, bt_a, bt_w} = raw;
   endtask

   // one clock with 'raw' applied; the model follows and every output is compared at the negedge
   task automatic cycle(input logic [4:0] raw, input string name);
      drive(raw);
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else        model_edge(raw);
      @(negedge clk);
      check(name, 32'(dut_vec()), 32'(model_vec()));
   endtask

   initial begin
      int pulses;
      int first;
      logic [4:0] r;
      int len;

      // raw, cycles, level, press, valid, dir, shoot (checked after the last cycle)
      tbl.push_back(mk(5'h1F,  9, 5'h00, 5'h00, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(5'h1F,  1, 5'h1F, 5'h1F, 1'b1, 2'b00, 1'b1));
      tbl.push_back(mk(5'h1F,  1, 5'h1F, 5'h00, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(5'h00,  9, 5'h1F, 5'h00, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(5'h00,  1, 5'h00, 5'h00, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(5'h01,  7, 5'h00, 5'h00, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(5'h00,  5, 5'h00, 5'h00, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(5'h01,  9, 5'h00, 5'h00, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(5'h01,  1, 5'h01, 5'h01, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(5'h01, 20, 5'h01, 5'h00, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(5'h00,  9, 5'h01, 5'h00, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(5'h00,  1, 5'h00, 5'h00, 1'b0, 2'b00, 1'b0));
      tbl.push_back(mk(5'h0A, 10, 5'h0A, 5'h0A, 1'b1, 2'b10, 1'b0));
      tbl.push_back(mk(5'h0A,  5, 5'h0A, 5'h00, 1'b1, 2'b10, 1'b0));
      tbl.push_back(mk(5'h0E, 10, 5'h0E, 5'h04, 1'b1, 2'b01, 1'b0));
      tbl.push_back(mk(5'h0A, 10, 5'h0A, 5'h00, 1'b1, 2'b10, 1'b0));
      tbl.push_back(mk(5'h00, 10, 5'h00, 5'h00, 1'b0, 2'b10, 1'b0));
      tbl.push_back(mk(5'h08, 10, 5'h08, 5'h08, 1'b1, 2'b11, 1'b0));
      tbl.push_back(mk(5'h00, 10, 5'h00, 5'h00, 1'b0, 2'b11, 1'b0));
      tbl.push_back(mk(5'h10, 10, 5'h10, 5'h10, 1'b0, 2'b11, 1'b1));
      tbl.push_back(mk(5'h10, 49, 5'h10, 5'h00, 1'b0, 2'b11, 1'b0));
      tbl.push_back(mk(5'h00, 10, 5'h00, 5'h00, 1'b0, 2'b11, 1'b0));

      // reset held with every button pressed
      rst_n = 1'b1;
      drive(5'h1F);
      model_reset();
      #1 rst_n = 1'b0;
      #1 check("reset_state", 32'(dut_vec()), 32'h0);
      for (int c = 0; c < 4; c++) cycle(5'h1F, "reset_hold");
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         for (int c = 0; c < tbl[k].n; c++) cycle(tbl[k].raw, "model");
         check($sformatf("tbl%0d", k), 32'(dut_vec()),
               32'({tbl[k].lvl, tbl[k].prs, tbl[k].vld, tbl[k].dir, tbl[k].sht}));
      end

      // shoot held 60 cycles
      pulses = 0;
      first  = -1;
      for (int c = 1; c <= 72; c++) begin
         cycle((c <= 60) ? 5'h10 : 5'h00, "model");
         if (shoot_pulse) begin
            pulses++;
            if (first < 0) first = c;
         end
      end
      check("shoot_count", 32'(pulses), AF ? 32'd5 : 32'd1);
      check("shoot_first", 32'(first), 32'd10);

      // reset while shoot is held (in REPEAT when autofire is built)
      for (int c = 1; c <= 40; c++) cycle(5'h10, "model");
      check("pre_reset_pulse", 32'(shoot_pulse), AF ? 32'd1 : 32'd0);
      rst_n = 1'b0;
      #1 check("reset_async", 32'(dut_vec()), 32'h0);
      for (int c = 0; c < 3; c++) cycle(5'h10, "model");
      rst_n = 1'b1;
      for (int c = 1; c <= 9; c++) cycle(5'h10, "model");
      check("rq_st_wait", 32'({btn_level, shoot_pulse}), 32'h0);
      cycle(5'h10, "model");
      check("rq_st_press", 32'({btn_level, btn_press, shoot_pulse}), 32'({5'h10, 5'h10, 1'b1}));
      for (int c = 0; c < 14; c++) cycle(5'h00, "model");

      // reset mid-debounce
      for (int c = 0; c < 5; c++) cycle(5'h01, "model");
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) cycle(5'h01, "model");
      rst_n = 1'b1;
      for (int c = 1; c <= 9; c++) cycle(5'h01, "model");
      check("rq_w_wait", 32'(btn_level), 32'h0);
      cycle(5'h01, "model");
      check("rq_w_press", 32'({btn_level, btn_press}), 32'({5'h01, 5'h01}));
      for (int c = 0; c < 12; c++) cycle(5'h00, "model");

      // random segments, mix of glitches and qualifying holds, occasional reset
      for (int seg = 0; seg < 300; seg++) begin
         r   = 5'($urandom_range(0, 31));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D)) : int'($urandom_range(D, 3 * D));
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            for (int c = 0; c < 2; c++) cycle(r, "rand_rst");
            rst_n = 1'b1;
         end
         for (int c = 0; c < len; c++) cycle(r, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
